// File: rtl/aidc_lite_zrle_buf.sv
`default_nettype none
// ============================================================================
// Module   : aidc_lite_zrle_buf
// Purpose  : Collects one 128B block (16 x 64-bit words) from the compression
//            engine and zero-word-run-length encodes it into a fixed 64B
//            buffer: slot0 holds a 16-bit nonzero bitmap, slots 1..7 hold the
//            nonzero words in arrival order. The engine reads the buffer back
//            as 16 x 32-bit beats, upper half of each slot first.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            comp_wren_i         - input word valid
//            comp_sop_i/eop_i    - first / last word of block (with wren)
//            comp_wdata_i[63:0]  - input word
//            comp_ready_o        - encoded block available (level)
//            zrle_blk_size_o[10:0] - encoded size in bits (1024 = incompressible)
//            comp_rden_i         - pop one 32-bit beat
//            comp_rdata_o[31:0]  - current read beat (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module aidc_lite_zrle_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        comp_wren_i,
  input  logic        comp_sop_i,
  input  logic        comp_eop_i,
  input  logic [63:0] comp_wdata_i,
  output logic        comp_ready_o,
  output logic [10:0] zrle_blk_size_o,
  input  logic        comp_rden_i,
  output logic [31:0] comp_rdata_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] slots [0:7];   // slot0 = {48'd0, bitmap}
  logic [3:0]  wr_idx;
  logic [3:0]  nnz;
  logic [3:0]  rd_ptr;

  // Per-word encode decision, shared by the start-of-block and fill paths.
  logic        start;
  logic        accept;
  logic [3:0]  idx;
  logic [3:0]  base_nnz;
  logic [15:0] base_map;
  logic        nz;
  logic [3:0]  nnz_nxt;
  logic [15:0] map_nxt;
  logic        store;
  logic        close;
  logic [10:0] size_nxt;
  logic [2:0]  store_slot;

  always_comb begin
    // A sop outside S_READY always (re)starts a block from a clean slate.
    start      = comp_wren_i && comp_sop_i && (state != S_READY);
    accept     = start || (comp_wren_i && (state == S_FILL));
    idx        = start ? 4'd0 : wr_idx;
    base_nnz   = start ? 4'd0 : nnz;
    base_map   = start ? 16'd0 : slots[0][15:0];
    nz         = |comp_wdata_i;
    nnz_nxt    = base_nnz;
    map_nxt    = base_map;
    if (nz) begin
      map_nxt[idx] = 1'b1;
      if (base_nnz < 4'd8) nnz_nxt = base_nnz + 4'd1;
    end
    // Only 7 data slots exist; further nonzero words just mark the bitmap.
    store      = nz && (base_nnz < 4'd7);
    store_slot = base_nnz[2:0] + 3'd1;
    close      = comp_eop_i || (idx == 4'd15);
    // 64*(1+nnz) for nnz<=7; 1024 flags an incompressible block.
    if (nnz_nxt[3]) size_nxt = 11'd1024;
    else            size_nxt = {1'b0, nnz_nxt + 4'd1, 6'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wr_idx          <= 4'd0;
      nnz             <= 4'd0;
      rd_ptr          <= 4'd0;
      comp_ready_o    <= 1'b0;
      zrle_blk_size_o <= 11'd0;
      for (int i = 0; i < 8; i++) slots[i] <= 64'd0;
    end else begin
      case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            if (start) begin
              for (int i = 1; i < 8; i++) slots[i] <= 64'd0;
            end
            if (store) slots[store_slot] <= comp_wdata_i;
            slots[0] <= {48'd0, map_nxt};
            nnz      <= nnz_nxt;
            wr_idx   <= idx + 4'd1;
            if (close) begin
              state           <= S_READY;
              comp_ready_o    <= 1'b1;
              zrle_blk_size_o <= size_nxt;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_READY: begin
          if (comp_rden_i) begin
            rd_ptr <= rd_ptr + 4'd1;   // wraps to 0 after the 16th pop
            if (rd_ptr == 4'd15) begin
              state        <= S_IDLE;
              comp_ready_o <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign comp_rdata_o = rd_ptr[0] ? slots[rd_ptr[3:1]][31:0]
                                  : slots[rd_ptr[3:1]][63:32];

endmodule
`default_nettype wire

// File: doc/aidc_lite_zrle_buf.md
# aidc_lite_zrle_buf

- **Function:** collects one 128B block as 16 64-bit words from the compression engine and zero-word-run-length encodes it into a fixed 64B output buffer.
- **Readback:** the engine reads the buffer back as 16 32-bit beats for its AHB write burst.
- **Position:** directly downstream of the comp engine's 32→64 packer, and upstream of its write-back path.
- **Format:** a 16-bit nonzero bitmap followed by the nonzero words in order. A reported size lets software detect incompressible blocks.

## Interface
Parameters: none. Fixed values are 16 input words per block, 8 output slots of 64 bits, and 16 read beats.
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- comp_wren_i  input  1  input word valid
- comp_sop_i  input  1  first word of block (valid with wren)
- comp_eop_i  input  1  last word of block (valid with wren)
- comp_wdata_i  input  64  input word; [63:32] is the lower address
- comp_ready_o  output  1  encoded block available for readout (level)
- zrle_blk_size_o  output  11  encoded size in bits; valid while comp_ready_o=1
- comp_rden_i  input  1  pop one 32-bit beat
- comp_rdata_o  output  32  current read beat (combinational from buffer and read pointer)

## Operation
- **States:**
  - S_IDLE: waits for wren&sop.
  - S_FILL: accumulates words.
  - S_READY: encoded block held; comp_ready_o=1.
- **Encoding buffer:** slot[0..7] of 64 bits.
  - slot0 = {48'd0, bitmap[15:0]}.
  - Bit i of bitmap is 1 iff input word i ≠ 0.
  - slots 1..7 hold the nonzero words in arrival order. Unused slots read 0.
- **Counters:**
  - wr_idx (4b): index of the incoming word.
  - nnz (4b): nonzero count, saturating at 8.
  - rd_ptr (4b): read beat index.
- **Word store:** a nonzero word with nnz<7 is written to slot[nnz+1]. A nonzero word with nnz≥7 only sets its bitmap bit and increments nnz (to 8 max).
- **Size, computed when S_FILL→S_READY:**
  - nnz≤7: 64*(1+nnz). Range is 64..512.
  - nnz≥8: 1024. This flags the block incompressible; the buffer still holds the bitmap and the first 7 nonzero words.
- **Readout:** comp_rdata_o = rd_ptr[0] ? slot[rd_ptr[3:1]][31:0] : slot[rd_ptr[3:1]][63:32].
- **S_IDLE:** wren&sop clears the bitmap, nnz and all slots; word 0 is processed; wr_idx←1; go to S_FILL. If eop is also set, go directly to S_READY. wren without sop is ignored.
- **S_FILL:** wren processes the word at wr_idx, then wr_idx increments.
  - eop, or wr_idx==15: go to S_READY. A block longer than 16 words is closed at the 16th word; later words are ignored until the next sop.
  - sop while in S_FILL: restart the block as in S_IDLE. The partial block is discarded.
- **S_READY:**
  - Any wren is ignored.
  - rden: rd_ptr increments. On the pop with rd_ptr==15, go to S_IDLE and set rd_ptr←0.
  - rden outside S_READY is ignored.
- **Reset:**
  - state S_IDLE.
  - rd_ptr, wr_idx, nnz, bitmap and all slots set to 0.
  - comp_ready_o=0, zrle_blk_size_o=0, comp_rdata_o=0.

## Timing
- **Write accept:** a word is accepted on the rising edge where wren=1.
- **Ready latency:** comp_ready_o rises the cycle after the eop word's edge, i.e. 1-cycle latency. zrle_blk_size_o is registered and valid in the same cycle.
- **Read beats:** comp_rdata_o is valid combinationally in the same cycle as rden. The pointer advances on the rden edge, so the next beat appears the following cycle. Back-to-back rden is sustained at 1 beat/cycle.
- **End of readout:** comp_ready_o falls the cycle after the 16th pop.
- **Next block:** a sop in that same cycle is accepted, giving zero bubble between blocks.
- **Simultaneous wren and the 16th rden:** the write is ignored, because the state is still S_READY on that edge.
- **Reset mid-fill or mid-readout:** the block is lost and all outputs return to their reset values on the next edge.

## Test plan
- **All-zero block:** 16 zero words, sop/eop → comp_ready_o=1 one cycle after eop; size=64; 16 pops all read 0x00000000.
- **Single nonzero word:** word5=0x1122334455667788, others 0 → bitmap 0x0020; size=128; pops 0..3 read 0x00000000, 0x00000020, 0x11223344, 0x55667788; pops 4..15 read 0.
- **Saturation:** words 0..8 = i+1 (9 nonzero) → bitmap 0x01FF; size=1024; slots 1..7 = 1..7; word 9 not stored.
- **Early eop and restart:**
  - eop on word 3 (words 0xA,0,0,0xB) → bitmap 0x0009; size=192.
  - Separately, sop mid-fill → the earlier data is absent from the result.
- **Back-to-back blocks:** sop of block 2 in the cycle after the 16th pop → block 2 accepted with no loss.
- **Ignored writes:** wren during S_READY leaves block 1 readout intact.
- **Reset during S_READY after 5 pops:** comp_ready_o=0, size=0, rdata=0; a following block encodes correctly.
